// File: rtl/spi_bus_arbiter_if.sv
// Bus bundle between SPI requesters/engine and the spi_bus_arbiter.
// The slave side is the arbiter; the master side is the requesters plus engine.
interface spi_bus_arbiter_if #(
  parameter int NUM_REQ = 3
);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [1:0]         power_mode;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] urgent;
  logic [NUM_REQ-1:0] gnt;
  logic               eng_start;
  logic [SEL_W-1:0]   eng_sel;
  logic               eng_done;
  logic [NUM_REQ-1:0] done;
  logic               timeout_err;
  logic               busy;

  modport slave (
    input  power_mode, req, urgent, eng_done,
    output gnt, eng_start, eng_sel, done, timeout_err, busy
  );

  modport master (
    output power_mode, req, urgent, eng_done,
    input  gnt, eng_start, eng_sel, done, timeout_err, busy
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter with urgent override for a shared SPI engine.
// One transaction at a time: IDLE -> START (1 cycle) -> ACTIVE (until done or
// timeout) -> GAP (GAP_CYC cycles) -> IDLE. All outputs come from flops.
module spi_bus_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 4
) (
  input  logic               spi_clk,
  input  logic               rst_n,
  spi_bus_arbiter_if.slave   bus
);
  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [SEL_W:0]     NUM_REQ_EXT = (SEL_W+1)'(NUM_REQ);
  localparam logic [SEL_W-1:0]   LAST_IDX    = SEL_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST    = GAP_W'(GAP_CYC - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0    = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               start_q, start_d;
  logic               tmo_q, tmo_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] urg_s;
  logic [NUM_REQ-1:0] pool_s;
  logic [NUM_REQ-1:0] pool_shift_s;
  logic [SEL_W:0]     idx_ext_s;
  logic               pick_any_s;
  logic [SEL_W-1:0]   pick_idx_s;

  // Requests allowed to compete under the current power mode.
  always_comb begin
    elig_s = '0;
    case (bus.power_mode)
      2'b00:   elig_s = bus.req;
      2'b01:   elig_s = bus.req & bus.urgent;
      default: elig_s = '0;
    endcase
  end

  assign urg_s  = elig_s & bus.urgent;
  assign pool_s = (|urg_s) ? urg_s : elig_s;

  // First set bit of the pool at or after rr_ptr, wrapping; scanning backwards
  // leaves the closest candidate as the final assignment.
  always_comb begin
    pick_any_s   = 1'b0;
    pick_idx_s   = '0;
    idx_ext_s    = '0;
    pool_shift_s = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx_ext_s = {1'b0, rr_q} + (SEL_W+1)'(i);
      if (idx_ext_s >= NUM_REQ_EXT) begin
        idx_ext_s = idx_ext_s - NUM_REQ_EXT;
      end else begin
        idx_ext_s = idx_ext_s;
      end
      pool_shift_s = pool_s >> idx_ext_s[SEL_W-1:0];
      if (pool_shift_s[0]) begin
        pick_any_s = 1'b1;
        pick_idx_s = idx_ext_s[SEL_W-1:0];
      end else begin
        pick_any_s = pick_any_s;
      end
    end
  end

  // Next-state and next-output decode; pulses default low every cycle.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    start_d = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_d = ST_START;
          gnt_d   = ONE_HOT0 << pick_idx_s;
          sel_d   = pick_idx_s;
          start_d = 1'b1;
        end else begin
          gnt_d = '0;
        end
      end
      ST_START: begin
        state_d = ST_ACTIVE;
        cnt_d   = '0;
      end
      ST_ACTIVE: begin
        if (bus.eng_done || (cnt_q == CNT_LAST)) begin
          state_d = ST_GAP;
          gnt_d   = '0;
          gap_d   = '0;
          rr_d    = (sel_q == LAST_IDX) ? '0 : (sel_q + SEL_W'(1));
          if (bus.eng_done) begin
            done_d = ONE_HOT0 << sel_q;
          end else begin
            tmo_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        gnt_d = '0;
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge spi_clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.eng_start   = start_q;
  assign bus.eng_sel     = sel_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = tmo_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: grant-decision table plus hand-written
// multi-cycle sequences (timing, back-to-back, timeout, reset, sleep).
module tb_spi_bus_arbiter;
  localparam int NR  = 3;
  localparam int TMO = 16;
  localparam int GAP = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  spi_bus_arbiter_if #(.NUM_REQ(NR)) bus ();

  spi_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
    .spi_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] prime;    // 3: none; else run one txn on this index first
    logic [1:0] mode;
    logic [2:0] req;
    logic [2:0] urg;
    logic [2:0] exp_gnt;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.power_mode = 2'b00;
    bus.req = 3'b000;
    bus.urgent = 3'b000;
    bus.eng_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 60) begin
      step();
      n++;
    end
    chk("wait_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.eng_start && n < 40);
    chk("start_seen", {31'd0, bus.eng_start}, 32'd1);
  endtask

  task automatic run_txn(input logic [1:0] idx);
    int n;
    bus.power_mode = 2'b00;
    bus.req = 3'b001 << idx;
    wait_start(n);
    bus.req = 3'b000;
    step();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n;
    int starts;
    logic done_seen;
    logic [1:0] order [4];
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd0;

    //            prime  mode   req     urg     gnt     sel
    vecs[0]  = '{2'd3, 2'b00, 3'b001, 3'b000, 3'b001, 2'd0};
    vecs[1]  = '{2'd3, 2'b00, 3'b011, 3'b010, 3'b010, 2'd1};
    vecs[2]  = '{2'd3, 2'b01, 3'b101, 3'b000, 3'b000, 2'd0};
    vecs[3]  = '{2'd3, 2'b10, 3'b111, 3'b111, 3'b000, 2'd0};
    vecs[4]  = '{2'd3, 2'b11, 3'b111, 3'b000, 3'b000, 2'd0};
    vecs[5]  = '{2'd0, 2'b00, 3'b101, 3'b000, 3'b100, 2'd2};
    vecs[6]  = '{2'd1, 2'b00, 3'b011, 3'b000, 3'b001, 2'd0};
    vecs[7]  = '{2'd0, 2'b00, 3'b111, 3'b101, 3'b100, 2'd2};
    vecs[8]  = '{2'd3, 2'b01, 3'b111, 3'b110, 3'b010, 2'd1};
    vecs[9]  = '{2'd1, 2'b01, 3'b011, 3'b011, 3'b001, 2'd0};
    vecs[10] = '{2'd3, 2'b00, 3'b000, 3'b111, 3'b000, 2'd0};
    vecs[11] = '{2'd3, 2'b00, 3'b110, 3'b001, 3'b010, 2'd1};
    vecs[12] = '{2'd1, 2'b00, 3'b111, 3'b000, 3'b100, 2'd2};

    // Reset state
    do_reset();
    chk("rst_gnt", {29'd0, bus.gnt}, 32'd0);
    chk("rst_start", {31'd0, bus.eng_start}, 32'd0);
    chk("rst_sel", {30'd0, bus.eng_sel}, 32'd0);
    chk("rst_done", {29'd0, bus.done}, 32'd0);
    chk("rst_tmo", {31'd0, bus.timeout_err}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);

    // Grant-decision table
    for (int v = 0; v < 13; v++) begin
      do_reset();
      if (vecs[v].prime != 2'd3) run_txn(vecs[v].prime);
      bus.power_mode = vecs[v].mode;
      bus.req = vecs[v].req;
      bus.urgent = vecs[v].urg;
      step();
      chk($sformatf("v%0d_gnt", v), {29'd0, bus.gnt}, {29'd0, vecs[v].exp_gnt});
      chk($sformatf("v%0d_start", v), {31'd0, bus.eng_start}, {31'd0, |vecs[v].exp_gnt});
      chk($sformatf("v%0d_busy", v), {31'd0, bus.busy}, {31'd0, |vecs[v].exp_gnt});
      if (vecs[v].exp_gnt != 3'b000) begin
        chk($sformatf("v%0d_sel", v), {30'd0, bus.eng_sel}, {30'd0, vecs[v].exp_sel});
        bus.req = 3'b000;
        bus.urgent = 3'b000;
        step();
        bus.eng_done = 1'b1;
        step();
        bus.eng_done = 1'b0;
        chk($sformatf("v%0d_done", v), {29'd0, bus.done}, {29'd0, vecs[v].exp_gnt});
        wait_idle();
      end else begin
        repeat (3) step();
        chk($sformatf("v%0d_idle_gnt", v), {29'd0, bus.gnt}, 32'd0);
        chk($sformatf("v%0d_idle_busy", v), {31'd0, bus.busy}, 32'd0);
      end
    end

    // Single-transaction cycle timing
    do_reset();
    bus.req = 3'b001;                         // cycle 0
    step();                                   // cycle 1
    chk("t_gnt_c1", {29'd0, bus.gnt}, 32'd1);
    chk("t_start_c1", {31'd0, bus.eng_start}, 32'd1);
    bus.req = 3'b000;
    step();                                   // cycle 2
    chk("t_start_c2", {31'd0, bus.eng_start}, 32'd0);
    chk("t_gnt_c2", {29'd0, bus.gnt}, 32'd1);
    repeat (3) step();                        // cycle 5
    bus.eng_done = 1'b1;
    step();                                   // cycle 6
    bus.eng_done = 1'b0;
    chk("t_done_c6", {29'd0, bus.done}, 32'd1);
    chk("t_gnt_c6", {29'd0, bus.gnt}, 32'd0);
    step();                                   // cycle 7
    chk("t_done_c7", {29'd0, bus.done}, 32'd0);
    repeat (2) step();                        // cycle 9
    chk("t_busy_c9", {31'd0, bus.busy}, 32'd1);
    step();                                   // cycle 10
    chk("t_busy_c10", {31'd0, bus.busy}, 32'd0);

    // Back-to-back round robin with all requesting
    do_reset();
    bus.req = 3'b111;
    for (int t = 0; t < 4; t++) begin
      wait_start(n);
      if (t > 0) chk($sformatf("rr%0d_interval", t), n, 32'd5);
      chk($sformatf("rr%0d_sel", t), {30'd0, bus.eng_sel}, {30'd0, order[t]});
      chk($sformatf("rr%0d_gnt", t), {29'd0, bus.gnt}, {29'd0, 3'b001 << order[t]});
      repeat (3) step();
      bus.eng_done = 1'b1;
      step();
      bus.eng_done = 1'b0;
      chk($sformatf("rr%0d_done", t), {29'd0, bus.done}, {29'd0, 3'b001 << order[t]});
    end
    bus.req = 3'b000;
    wait_idle();

    // Timeout, then pointer advances to requester 1
    do_reset();
    bus.req = 3'b001;
    wait_start(n);
    bus.req = 3'b011;
    n = 0;
    done_seen = 1'b0;
    do begin
      step();
      n++;
      if (bus.done != 3'b000) done_seen = 1'b1;
    end while (!bus.timeout_err && n < 40);
    chk("tmo_latency", n, TMO + 1);
    chk("tmo_no_done", {31'd0, done_seen}, 32'd0);
    chk("tmo_gnt", {29'd0, bus.gnt}, 32'd0);
    step();
    chk("tmo_pulse", {31'd0, bus.timeout_err}, 32'd0);
    wait_start(n);
    chk("tmo_next_sel", {30'd0, bus.eng_sel}, 32'd1);
    bus.req = 3'b000;
    step();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    wait_idle();

    // Done in the same cycle the timeout would fire
    do_reset();
    bus.req = 3'b001;
    wait_start(n);
    bus.req = 3'b000;
    repeat (TMO) step();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    chk("tie_done", {29'd0, bus.done}, 32'd1);
    chk("tie_tmo", {31'd0, bus.timeout_err}, 32'd0);
    wait_idle();

    // eng_done ignored in IDLE, START and GAP
    do_reset();
    bus.eng_done = 1'b1;
    step();
    chk("ign_idle_done", {29'd0, bus.done}, 32'd0);
    bus.eng_done = 1'b0;
    bus.req = 3'b001;
    step();                                   // START
    bus.eng_done = 1'b1;
    bus.req = 3'b000;
    step();                                   // ACTIVE
    bus.eng_done = 1'b0;
    chk("ign_start_done", {29'd0, bus.done}, 32'd0);
    step();
    chk("ign_start_busy", {31'd0, bus.busy}, 32'd1);
    chk("ign_start_gnt", {29'd0, bus.gnt}, 32'd1);
    bus.eng_done = 1'b1;
    step();
    chk("ign_done_ok", {29'd0, bus.done}, 32'd1);
    step();                                   // eng_done still high in GAP
    chk("ign_gap_done", {29'd0, bus.done}, 32'd0);
    bus.eng_done = 1'b0;
    wait_idle();

    // SLEEP during ACTIVE completes, then no further grant
    do_reset();
    bus.req = 3'b111;
    wait_start(n);
    bus.power_mode = 2'b10;
    step();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    chk("sleep_done", {29'd0, bus.done}, 32'd1);
    starts = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (bus.eng_start) starts++;
    end
    chk("sleep_no_start", starts, 32'd0);
    chk("sleep_busy", {31'd0, bus.busy}, 32'd0);

    // Reset mid-ACTIVE with eng_done, then first arbitration after reset
    do_reset();
    bus.req = 3'b001;
    wait_start(n);
    step();                                   // ACTIVE
    rst_n = 1'b0;
    bus.eng_done = 1'b1;
    bus.req = 3'b010;
    step();
    chk("mrst_gnt", {29'd0, bus.gnt}, 32'd0);
    chk("mrst_done", {29'd0, bus.done}, 32'd0);
    chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mrst_sel", {30'd0, bus.eng_sel}, 32'd0);
    chk("mrst_start", {31'd0, bus.eng_start}, 32'd0);
    chk("mrst_tmo", {31'd0, bus.timeout_err}, 32'd0);
    bus.eng_done = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_gnt", {29'd0, bus.gnt}, 32'd2);
    chk("post_rst_start", {31'd0, bus.eng_start}, 32'd1);
    chk("post_rst_sel", {30'd0, bus.eng_sel}, 32'd1);
    bus.req = 3'b000;
    step();
    bus.eng_done = 1'b1;
    step();
    bus.eng_done = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3, number of SPI requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024, ACTIVE cycles allowed before abort (>=2).
REQ-003 SHALL have parameter GAP_CYC, default 4, idle cycles between transactions (>=1).
REQ-004 SHALL have port spi_clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port power_mode  input  2  00 NORMAL, 01 LOW, 10 SLEEP, 11 treated as SLEEP.
REQ-007 SHALL have port req  input  NUM_REQ  per-requester transaction request, level.
REQ-008 SHALL have port urgent  input  NUM_REQ  per-requester priority flag, valid only with matching req bit.
REQ-009 SHALL have port gnt  output  NUM_REQ  one-hot grant, held for whole transaction.
REQ-010 SHALL have port eng_start  output  1  single-cycle start pulse to shared SPI engine.
REQ-011 SHALL have port eng_sel  output  $clog2(NUM_REQ)  index of granted requester.
REQ-012 SHALL have port eng_done  input  1  engine completion pulse.
REQ-013 SHALL have port done  output  NUM_REQ  single-cycle completion pulse to granted requester.
REQ-014 SHALL have port timeout_err  output  1  single-cycle pulse on aborted transaction.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, START, ACTIVE, GAP; all outputs registered.
REQ-017 Eligibility SHALL be: NORMAL all req bits; LOW only req&urgent; SLEEP/11 none.
REQ-018 In IDLE, if any eligible urgent request, winner SHALL be first eligible urgent bit at or after rr_ptr (wrapping); else first eligible bit at or after rr_ptr.
REQ-019 Eligible request sampled in IDLE at cycle N SHALL give state START, gnt[winner]=1, eng_sel=winner, eng_start=1 during cycle N+1.
REQ-020 START SHALL last exactly one cycle, then ACTIVE; eng_start low outside START.
REQ-021 In ACTIVE, eng_done high at cycle M SHALL give done[winner]=1, gnt=0, state GAP during cycle M+1.
REQ-022 ACTIVE cycle counter SHALL start at 0 on entry; if it reaches TIMEOUT_CYC-1 with eng_done low, next cycle SHALL have timeout_err=1, done=0, gnt=0, state GAP.
REQ-023 eng_done and timeout in the same cycle: done SHALL win, no timeout_err.
REQ-024 eng_done in IDLE, START or GAP SHALL be ignored.
REQ-025 GAP SHALL last exactly GAP_CYC cycles, then IDLE; no grant during GAP.
REQ-026 rr_ptr SHALL update to (winner+1) mod NUM_REQ on leaving ACTIVE (done or timeout).
REQ-027 Deasserting req or changing power_mode during START/ACTIVE SHALL NOT abort; transaction completes normally.
REQ-028 gnt SHALL never have more than one bit set; done and timeout_err SHALL never both be high.

Reset
REQ-029 rst_n low at a rising edge SHALL force state IDLE, rr_ptr=0, counters=0, gnt=0, eng_start=0, eng_sel=0, done=0, timeout_err=0, busy=0 on next cycle, including mid-transaction.
REQ-030 First arbitration after reset SHALL occur in the first IDLE cycle with rst_n high.

Verification
REQ-031 NORMAL, req=001 at cycle 0, eng_done at cycle 5 -> gnt=001 and eng_start cycle 1, done=001 cycle 6, busy low from cycle 10 (GAP_CYC=4).
REQ-032 NORMAL, req=111 held, eng_done 3 cycles after each start -> grant order 0,1,2,0; no idle cycles beyond GAP.
REQ-033 rr_ptr=0, req=011, urgent=010 -> gnt=010 first; LOW mode, req=101, urgent=000 -> no grant, busy stays 0.
REQ-034 req=001, eng_done never asserted -> timeout_err pulse exactly TIMEOUT_CYC+1 cycles after eng_start, done stays 0, next grant goes to requester 1 if requesting.
REQ-035 SLEEP asserted during ACTIVE -> transaction completes with done pulse; no new grant while SLEEP.
REQ-036 rst_n low in ACTIVE, eng_done high same cycle -> all outputs zero next cycle, no done pulse.
